// File: rtl/de_arb_pkg.sv
// Shared types and constants for the frame-store drawing-engine port arbiter.
package de_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } arb_state_e;

  localparam int CNT_W = 8;

  // Byte lanes are active-low, so an idle port presents all lanes disabled.
  localparam logic [3:0] NBYTE_IDLE = 4'b1111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/de_arb_if.sv
// One drawing-engine request/acknowledge port; the same shape serves both clients and the frame store.
interface de_arb_if #(
  parameter int ADDR_W = 18
);
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        nbyte;
  logic              rnw;
  logic [31:0]       w_data;
  logic [31:0]       r_data;

  modport master (output req, addr, nbyte, rnw, w_data, input ack, r_data);
  modport slave  (input req, addr, nbyte, rnw, w_data, output ack, r_data);
endinterface

// File: rtl/de_arb_mux.sv
// Owner-select mux: forwards the granted client to the frame store and routes ack/read data back.
module de_arb_mux #(
  parameter int ADDR_W = 18
) (
  input  logic     grant_a,
  input  logic     grant_b,
  de_arb_if.slave  a,
  de_arb_if.slave  b,
  de_arb_if.master de
);
  import de_arb_pkg::*;

  logic [ADDR_W-1:0] addr_sel;

  always_comb begin
    de.req    = 1'b0;
    addr_sel  = {ADDR_W{1'b0}};
    de.nbyte  = NBYTE_IDLE;
    de.rnw    = 1'b0;
    de.w_data = 32'h0;
    if (grant_a) begin
      de.req    = a.req;
      addr_sel  = a.addr;
      de.nbyte  = a.nbyte;
      de.rnw    = a.rnw;
      de.w_data = a.w_data;
    end else if (grant_b) begin
      de.req    = b.req;
      addr_sel  = b.addr;
      de.nbyte  = b.nbyte;
      de.rnw    = b.rnw;
      de.w_data = b.w_data;
    end
  end

  assign de.addr  = addr_sel;

  assign a.ack    = de.ack & grant_a;
  assign b.ack    = de.ack & grant_b;
  assign a.r_data = grant_a ? de.r_data : 32'h0;
  assign b.r_data = grant_b ? de.r_data : 32'h0;

endmodule

// File: rtl/de_arbiter.sv
// Round-robin, burst-limited arbiter for the frame-store drawing-engine port.
// Define DE_ARB_PRIORITY_A_EN to give client A fixed priority with no burst limit.
module de_arbiter #(
  parameter int BURST_MAX = 8,
  parameter int ADDR_W    = 18
) (
  input  logic     clk,
  input  logic     rst_n,
  de_arb_if.slave  a,
  de_arb_if.slave  b,
  de_arb_if.master de,
  output logic     grant_a,
  output logic     grant_b
);
  // state    | meaning
  // ST_IDLE  | no owner, downstream request held low
  // ST_GNT_A | client A owns the frame-store port
  // ST_GNT_B | client B owns the frame-store port
  import de_arb_pkg::*;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_e       state, state_d, other;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             last_b, last_b_d;
  logic             own_req, oth_req, release_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      last_b <= last_b_d;
    end
  end

`ifdef DE_ARB_PRIORITY_A_EN
  // B yields at its next transfer boundary whenever A is waiting.
  assign release_hit = (state == ST_GNT_B);
`else
  assign release_hit = (cnt == BURST_LAST);
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    last_b_d = last_b;
    own_req  = 1'b0;
    oth_req  = 1'b0;
    other    = ST_IDLE;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (a.req && b.req) begin
`ifdef DE_ARB_PRIORITY_A_EN
          state_d = ST_GNT_A;
`else
          state_d = last_b ? ST_GNT_A : ST_GNT_B;
`endif
        end else if (a.req) begin
          state_d = ST_GNT_A;
        end else if (b.req) begin
          state_d = ST_GNT_B;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        own_req = (state == ST_GNT_A) ? a.req : b.req;
        oth_req = (state == ST_GNT_A) ? b.req : a.req;
        other   = (state == ST_GNT_A) ? ST_GNT_B : ST_GNT_A;
        // Only a transfer boundary (ack) or a dropped request may move the grant.
        if (de.ack) begin
          if (oth_req && release_hit) begin
            state_d  = other;
            cnt_d    = '0;
            last_b_d = (state == ST_GNT_B);
          end else begin
            cnt_d = sat_inc(cnt);
          end
        end else if (!own_req) begin
          state_d  = oth_req ? other : ST_IDLE;
          cnt_d    = '0;
          last_b_d = (state == ST_GNT_B);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    grant_a = (state == ST_GNT_A);
    grant_b = (state == ST_GNT_B);
  end

  de_arb_mux #(
    .ADDR_W(ADDR_W)
  ) u_mux (
    .grant_a(grant_a),
    .grant_b(grant_b),
    .a      (a),
    .b      (b),
    .de     (de)
  );

endmodule

// File: doc/de_arbiter.md
Name: de_arbiter

Overview:
- Shares the single frame-store drawing-engine port (de_req/de_ack, 18-bit word address, byte-lane enables, 32-bit data) between two requesters: client A (dithering drawer) and client B (a second drawing or readback unit).
- Sits between the drawing engines and the frame-store interface.
- Arbitration is round-robin with a burst limit, so a drawer that holds its request high continuously cannot starve the other client.

Parameters:
- BURST_MAX, 8, maximum consecutive acknowledged transfers for one client while the other client is requesting; legal range 1..255.
- ADDR_W, 18, width of the word address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- a_req  in  1  client A transfer request
- a_ack  out  1  client A transfer done
- a_addr  in  ADDR_W  client A word address
- a_nbyte  in  4  client A byte-lane enables, active-low
- a_rnw  in  1  client A read-not-write
- a_w_data  in  32  client A write data
- a_r_data  out  32  client A read data
- b_req, b_ack, b_addr, b_nbyte, b_rnw, b_w_data, b_r_data: same as client A, for client B
- de_req  out  1  downstream request
- de_ack  in  1  downstream done, one-cycle pulse per transfer
- de_addr  out  ADDR_W  downstream address
- de_nbyte  out  4  downstream byte-lane enables
- de_rnw  out  1  downstream read-not-write
- de_w_data  out  32  downstream write data
- de_r_data  in  32  downstream read data
- grant_a, grant_b  out  1  current owner, for status and debug

Behaviour:
- Client protocol: a client raises req with stable addr/nbyte/rnw/w_data and holds them until it sees ack. The client may then hold req for the next transfer, or drop it. A client must not withdraw req before ack.
- States: IDLE, GNT_A, GNT_B. State, burst counter (8 bits) and last-owner pointer are registered. Reset values: IDLE, counter 0, pointer = B, so A wins the first contention.
- IDLE:
  - a_req only -> GNT_A.
  - b_req only -> GNT_B.
  - Both -> the client that is not the last owner.
  - The counter clears on entry to any grant state.
- Latency: request in cycle n (arbiter in IDLE) -> de_req high in cycle n+1.
- Downstream signals are a combinational mux from the owner's inputs, selected by the registered grant:
  - de_req = owner_req & granted.
  - Everything else is 0 in IDLE; de_nbyte is 4'b1111 in IDLE.
- Acknowledge routing:
  - x_ack = de_ack & grant_x, combinational.
  - x_r_data = de_r_data when grant_x, else 0.
  - The non-owner's ack is always 0.
- At a de_ack edge while in GNT_x:
  - If the other client is requesting and counter == BURST_MAX-1: switch to the other grant, counter = 0, pointer = x.
  - Otherwise: counter increments, saturating at 255.
- Owner req low with de_ack low:
  - Other client requesting -> switch to it.
  - Otherwise -> IDLE.
  - The pointer is updated in both cases.
- Grant never changes while de_req is high and de_ack has not yet arrived. A transfer in progress is never retargeted.
- The counter is compared only while the other client is requesting. An uncontended owner keeps the grant indefinitely.
- de_ack arriving in IDLE is ignored; neither client is acked.
- rst_n low at any time:
  - Asynchronously forces IDLE, counter 0, pointer B.
  - de_req, a_ack, b_ack, grant_a and grant_b go to 0 immediately.
  - A transfer in progress is abandoned; clients re-request after reset.

Optional Feature:
- Macro DE_ARB_PRIORITY_A_EN.
- Defined:
  - Client A has fixed priority and no burst limit.
  - On contention, A always wins.
  - B is released at its next de_ack edge if a_req is high.
- Undefined: round-robin with BURST_MAX, as described above.

Decomposition:
- Package de_arb_pkg: state encoding (IDLE/GNT_A/GNT_B), counter width, and the IDLE default for de_nbyte.
- One natural sub-module, de_arb_mux: a pure combinational owner-select mux for the downstream and return paths. The FSM and counter stay in de_arbiter.

Test Plan:
- A alone, a_addr=18'h00100, a_nbyte=4'b1110, write -> de_req=1 one cycle later with de_addr=18'h00100 and de_nbyte=4'b1110; de_ack pulse -> a_ack=1 the same cycle, b_ack=0.
- a_req and b_req rise together after reset -> A granted first. With A held for 2 transfers and BURST_MAX=8, B waits. A drops req -> B granted the next cycle.
- BURST_MAX=4, both held high, de_ack every cycle -> acked sequence AAAABBBBAAAA, with no cycle where both acks are high.
- B read, de_r_data=32'hDEADBEEF with de_ack -> b_r_data=32'hDEADBEEF and a_r_data=0. Then b_req drops with a_req low -> IDLE and de_req=0 next cycle.
- rst_n pulsed low while GNT_B with de_req high -> de_req and grants are 0 immediately. After release with both requesting -> A granted.
- With DE_ARB_PRIORITY_A_EN defined, both held high, de_ack every cycle -> only A acked. B is acked only in cycles after a_req drops.
